// File: rtl/platform_scanner_multi.sv
// Raster-synchronous scanner collecting up to NUM_SLOTS platform runs below the player per frame.
// The working set is committed to stable outputs on the VS falling edge.
module platform_scanner_multi #(
    parameter int unsigned         NUM_SLOTS    = 4,
    parameter int unsigned         COORD_W      = 10,
    parameter int unsigned         COLOR_W      = 5,
    parameter logic [COLOR_W-1:0]  PLAT_COLOR_A = 5'h17,
    parameter logic [COLOR_W-1:0]  PLAT_COLOR_B = 5'h18,
    parameter int unsigned         X_LIMIT      = 500,
    parameter int unsigned         MIN_RUN      = 2,
    parameter int unsigned         PIX_LAT      = 1,
    parameter bit                  SAME_ROW     = 1'b1
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           VS,
    input  logic                           blank,
    input  logic                           ScanEnable,
    input  logic [COORD_W-1:0]             DrawX,
    input  logic [COORD_W-1:0]             DrawY,
    input  logic [COORD_W-1:0]             PlayerY,
    input  logic [COORD_W-1:0]             PlayerHeight,
    input  logic [COLOR_W-1:0]             backgroundPixel,
    output logic [NUM_SLOTS*COORD_W-1:0]   PlatformX1,
    output logic [NUM_SLOTS*COORD_W-1:0]   PlatformX2,
    output logic [NUM_SLOTS*COORD_W-1:0]   PlatformY,
    output logic [NUM_SLOTS-1:0]           PlatformValid,
    output logic [3:0]                     PlatformCount,
    output logic                           FrameDone
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StClose = 2'd2;

    localparam logic [COORD_W-1:0] XLim    = COORD_W'(X_LIMIT);
    localparam logic [COORD_W-1:0] PixLat  = COORD_W'(PIX_LAT);
    localparam logic [COORD_W-1:0] One     = COORD_W'(1);
    localparam logic [COORD_W:0]   MinRun  = (COORD_W+1)'(MIN_RUN);
    localparam logic [COORD_W:0]   OneW    = (COORD_W+1)'(1);
    localparam logic [3:0]         NumSlot = 4'(NUM_SLOTS);

    logic                         vs_q;
    logic [1:0]                   state_q, state_d;
    logic [COORD_W-1:0]           run_x1_q, run_x1_d;
    logic [COORD_W-1:0]           run_x2_q, run_x2_d;
    logic [COORD_W-1:0]           run_y_q, run_y_d;
    logic [NUM_SLOTS*COORD_W-1:0] wx1_q, wx1_d, wx2_q, wx2_d, wy_q, wy_d;
    logic [3:0]                   wcnt_q, wcnt_d;
    logic                         lock_v_q, lock_v_d;
    logic [COORD_W-1:0]           lock_y_q, lock_y_d;
    logic [NUM_SLOTS*COORD_W-1:0] ox1_q, ox1_d, ox2_q, ox2_d, oy_q, oy_d;
    logic [NUM_SLOTS-1:0]         oval_q, oval_d;
    logic [3:0]                   ocnt_q, ocnt_d;
    logic                         fd_q, fd_d;

    logic               commit;
    logic               match;
    logic               below;
    logic               row_ok;
    logic               gate;
    logic [COORD_W:0]   floor_y;
    logic [COORD_W:0]   run_len;
    logic               run_long;

    assign commit   = vs_q & ~VS;
    assign match    = ((backgroundPixel == PLAT_COLOR_A) || (backgroundPixel == PLAT_COLOR_B))
                      && blank;
    assign floor_y  = {1'b0, PlayerY} + {1'b0, PlayerHeight};
    assign below    = {1'b0, DrawY} >= floor_y;
    assign row_ok   = !SAME_ROW || !lock_v_q || (DrawY == lock_y_q);
    // VS low counts as a closed gate so nothing is scanned during vertical blanking.
    assign gate     = below && ScanEnable && VS && (wcnt_q < NumSlot) && row_ok;
    assign run_len  = {1'b0, run_x2_q} - {1'b0, run_x1_q} + OneW;
    assign run_long = (run_x2_q >= run_x1_q) && (run_len >= MinRun);

    always_comb begin
        state_d  = state_q;
        run_x1_d = run_x1_q;
        run_x2_d = run_x2_q;
        run_y_d  = run_y_q;
        wx1_d    = wx1_q;
        wx2_d    = wx2_q;
        wy_d     = wy_q;
        wcnt_d   = wcnt_q;
        lock_v_d = lock_v_q;
        lock_y_d = lock_y_q;
        ox1_d    = ox1_q;
        ox2_d    = ox2_q;
        oy_d     = oy_q;
        oval_d   = oval_q;
        ocnt_d   = ocnt_q;
        fd_d     = 1'b0;

        case (state_q)
            StIdle: begin
                if (gate && match && (DrawX <= XLim)) begin
                    run_x1_d = DrawX - PixLat;
                    run_y_d  = DrawY;
                    state_d  = StRun;
                end
            end
            StRun: begin
                if (!gate) begin
                    state_d = StIdle;
                end else if (!match) begin
                    run_x2_d = DrawX - PixLat - One;
                    state_d  = StClose;
                end else if (DrawX >= XLim) begin
                    run_x2_d = XLim;
                    state_d  = StClose;
                end
            end
            StClose: begin
                state_d = StIdle;
                if (run_long && (wcnt_q < NumSlot)) begin
                    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
                        if (4'(i) == wcnt_q) begin
                            wx1_d[i*COORD_W +: COORD_W] = run_x1_q;
                            wx2_d[i*COORD_W +: COORD_W] = run_x2_q;
                            wy_d[i*COORD_W +: COORD_W]  = run_y_q;
                        end
                    end
                    wcnt_d = wcnt_q + 4'd1;
                    if (!lock_v_q) begin
                        lock_v_d = 1'b1;
                        lock_y_d = run_y_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Commit copies the pre-update working set; any run in flight is dropped.
        if (commit) begin
            for (int i = 0; i < int'(NUM_SLOTS); i++) begin
                if (4'(i) < wcnt_q) begin
                    ox1_d[i*COORD_W +: COORD_W] = wx1_q[i*COORD_W +: COORD_W];
                    ox2_d[i*COORD_W +: COORD_W] = wx2_q[i*COORD_W +: COORD_W];
                    oy_d[i*COORD_W +: COORD_W]  = wy_q[i*COORD_W +: COORD_W];
                    oval_d[i]                   = 1'b1;
                end else begin
                    ox1_d[i*COORD_W +: COORD_W] = '0;
                    ox2_d[i*COORD_W +: COORD_W] = '0;
                    oy_d[i*COORD_W +: COORD_W]  = '0;
                    oval_d[i]                   = 1'b0;
                end
            end
            ocnt_d   = wcnt_q;
            fd_d     = 1'b1;
            wx1_d    = '0;
            wx2_d    = '0;
            wy_d     = '0;
            wcnt_d   = 4'd0;
            lock_v_d = 1'b0;
            lock_y_d = '0;
            state_d  = StIdle;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            vs_q     <= 1'b1;
            state_q  <= StIdle;
            run_x1_q <= '0;
            run_x2_q <= '0;
            run_y_q  <= '0;
            wx1_q    <= '0;
            wx2_q    <= '0;
            wy_q     <= '0;
            wcnt_q   <= 4'd0;
            lock_v_q <= 1'b0;
            lock_y_q <= '0;
            ox1_q    <= '0;
            ox2_q    <= '0;
            oy_q     <= '0;
            oval_q   <= '0;
            ocnt_q   <= 4'd0;
            fd_q     <= 1'b0;
        end else begin
            vs_q     <= VS;
            state_q  <= state_d;
            run_x1_q <= run_x1_d;
            run_x2_q <= run_x2_d;
            run_y_q  <= run_y_d;
            wx1_q    <= wx1_d;
            wx2_q    <= wx2_d;
            wy_q     <= wy_d;
            wcnt_q   <= wcnt_d;
            lock_v_q <= lock_v_d;
            lock_y_q <= lock_y_d;
            ox1_q    <= ox1_d;
            ox2_q    <= ox2_d;
            oy_q     <= oy_d;
            oval_q   <= oval_d;
            ocnt_q   <= ocnt_d;
            fd_q     <= fd_d;
        end
    end

    assign PlatformX1    = ox1_q;
    assign PlatformX2    = ox2_q;
    assign PlatformY     = oy_q;
    assign PlatformValid = oval_q;
    assign PlatformCount = ocnt_q;
    assign FrameDone     = fd_q;

endmodule

// File: doc/platform_scanner_multi.md
Name: platform_scanner_multi

Overview:
- Raster-synchronous scanner that finds up to NUM_SLOTS horizontal platform segments below the player in one frame.
- A pixel belongs to a platform when backgroundPixel matches either of two palette indices.
- Results are collected into a working set during the active frame. They are committed to stable output registers at vertical sync, so physics/collision logic reads a consistent set for the whole next frame.
- Sits between the background palette lookup and the player motion/collision logic.

Parameters:
NUM_SLOTS, 4, number of platform segments stored per frame (1..8)
COORD_W, 10, width of X/Y coordinates
COLOR_W, 5, width of background palette index
PLAT_COLOR_A, 5'h17, first platform palette index
PLAT_COLOR_B, 5'h18, second platform palette index
X_LIMIT, 500, rightmost X considered; an open run is force-closed here
MIN_RUN, 2, minimum run width in pixels; shorter runs are discarded
PIX_LAT, 1, backgroundPixel lags DrawX by this many cycles
SAME_ROW, 1, 1 = accept runs only on the first row that yields a run; 0 = any qualifying row

Ports:
Clk  in  1  pixel clock, one pixel per cycle
Reset  in  1  synchronous, active-low reset
VS  in  1  vertical sync, active low
blank  in  1  1 = visible pixel
ScanEnable  in  1  scanning allowed this frame (not on platform, or scrolling)
DrawX  in  COORD_W  current raster X
DrawY  in  COORD_W  current raster Y
PlayerY  in  COORD_W  player top Y
PlayerHeight  in  COORD_W  player height
backgroundPixel  in  COLOR_W  palette index for pixel DrawX-PIX_LAT
PlatformX1  out  NUM_SLOTS*COORD_W  committed left X per slot; slot i occupies bits [i*COORD_W +: COORD_W]
PlatformX2  out  NUM_SLOTS*COORD_W  committed right X (inclusive) per slot
PlatformY  out  NUM_SLOTS*COORD_W  committed row per slot
PlatformValid  out  NUM_SLOTS  committed valid bits; slots fill from bit 0 upward
PlatformCount  out  4  number of committed valid slots
FrameDone  out  1  one-cycle pulse on commit

Behaviour:
- Reset low at a Clk edge: all outputs 0, working set cleared, FSM in IDLE, row lock cleared, VS history register set to 1.
- Match condition = (backgroundPixel==PLAT_COLOR_A || backgroundPixel==PLAT_COLOR_B) && blank.
- Gate condition (all must hold):
  - DrawY >= PlayerY+PlayerHeight, sum computed at COORD_W+1 bits so there is no wrap;
  - ScanEnable=1;
  - working count < NUM_SLOTS;
  - if SAME_ROW=1 and the row lock is set, DrawY == locked row.
- FSM states:
  - IDLE: if gate && match && DrawX<=X_LIMIT, latch X1=DrawX-PIX_LAT and Y=DrawY, go to RUN.
  - RUN, while match && DrawX<X_LIMIT: stay.
  - RUN, on !match: X2=DrawX-PIX_LAT-1, go to CLOSE.
  - RUN, on DrawX==X_LIMIT with match still true: X2=X_LIMIT, go to CLOSE.
  - RUN, if the gate drops (e.g. ScanEnable falls): abandon the run, go to IDLE, nothing stored.
  - CLOSE (1 cycle): if X2-X1+1 >= MIN_RUN, write the next free working slot, increment the working count, and set the row lock to Y if it is not already set. Go to IDLE. A match during CLOSE is not a new start; at least one cycle of IDLE lies between runs.
- Multiple runs per row are allowed until the slots are full. Once full, further runs are ignored.
- Commit: a VS falling edge (registered VS=1, VS=0) does the following in the same cycle:
  - copy the working set to the outputs, with unused slots driven as X1/X2/Y=0 and valid=0;
  - pulse FrameDone;
  - clear the working set and row lock;
  - force the FSM to IDLE.
  A run still open at that edge is discarded.
- While VS=0: no scanning; the working set stays clear.
- Outputs change only on reset or commit.
- Reset during VS low or mid-run: reset wins, with no commit and no FrameDone.

Test Plan:
1. Defaults: PlayerY=100, PlayerHeight=40; row 140 has pixels 0x17 at X 50..80, other rows none; VS falls -> slot0 = X1 50, X2 80, Y 140; Valid=0001; Count=1; FrameDone high for exactly 1 cycle.
2. Row 150 has runs at X 10..20, 30..31, 40..40, 60..70 (0x18) -> slots 10-20, 30-31, 60-70, all Y 150; the 1-pixel run is dropped; Count=3.
3. SAME_ROW=1, qualifying runs on rows 141 and 142 -> only row-141 runs committed. Same stimulus with SAME_ROW=0 -> both rows committed in raster order.
4. Run from X 480 continuing past 500 -> X2=500; six qualifying runs with NUM_SLOTS=4 -> Count=4, runs 5 and 6 ignored.
5. Run above PlayerY+PlayerHeight, or with ScanEnable=0 -> Valid=0, Count=0 after commit. ScanEnable dropped mid-run -> that run absent.
6. Reset pulled low mid-run and mid-VS -> all outputs 0, no FrameDone. The next full frame reports normally.
